f1_race_ctrl: RTL

// - Race-start sequencer and reaction timer that wraps the F1 start-light unit.
// - On a start request it fires one trigger pulse into the light unit, then tracks the light pattern it returns.
// - Once all lights go out it times the driver's reaction in ms ticks, detects false starts and reports the result.
// - Sits between the push-button inputs and the F1 light datapath; results go to the display logic.
//

---
 rtl/f1_race_ctrl_if.sv | 27 ++
 rtl/f1_race_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/f1_race_ctrl_if.sv
// Signal bundle between the F1 race-start controller, its button/light inputs
// and the display logic; the controller uses the slave modport.
interface f1_race_ctrl_if #(
   parameter int unsigned W = 10
);
   logic          start_btn;
   logic          react_btn;
   logic          ms_tick;
   logic [7:0]    lights;
   logic          trigger;
   logic          busy;
   logic          res_valid;
   logic [W-1:0]  reaction_ms;
   logic          false_start;
   logic          timeout;
   logic [W-1:0]  best_ms;

   modport slave (
      input  start_btn, react_btn, ms_tick, lights,
      output trigger, busy, res_valid, reaction_ms, false_start, timeout, best_ms
   );

   modport master (
      output start_btn, react_btn, ms_tick, lights,
      input  trigger, busy, res_valid, reaction_ms, false_start, timeout, best_ms
   );
endinterface

// File: rtl/f1_race_ctrl.sv
// Race-start sequencer and reaction timer around the F1 start-light unit.
// Optional BEST_TIME_EN macro builds the best (minimum) reaction-time tracker.
module f1_race_ctrl #(
   parameter int unsigned W         = 10,
   parameter int unsigned MAX_MS    = 999,
   parameter int unsigned SEQ_TO_MS = 4000
) (
   input  logic           clk,
   input  logic           rst,
   f1_race_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_SEQ, S_HOLD, S_TIMING, S_DONE, S_FAULT
   } state_t;

   state_t        r_state, w_next;
   logic          r_start_in, r_start_prev, r_react_in, r_react_prev;
   logic [W-1:0]  r_cnt;
   logic [11:0]   r_seq_cnt;
   logic          r_res_valid, r_false_start, r_timeout;
   logic [W-1:0]  r_reaction_ms;

   logic w_start_edge, w_react_edge;
   logic w_clr_flags, w_clr_cnt, w_clr_seq, w_inc_cnt, w_inc_seq;
   logic w_capture, w_set_fs, w_set_to;

   // Inputs are registered first, so an edge is seen one cycle after the level rises.
   assign w_start_edge = r_start_in & ~r_start_prev;
   assign w_react_edge = r_react_in & ~r_react_prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_start_in   <= 1'b0;
         r_start_prev <= 1'b0;
         r_react_in   <= 1'b0;
         r_react_prev <= 1'b0;
      end else begin
         r_start_in   <= bus.start_btn;
         r_start_prev <= r_start_in;
         r_react_in   <= bus.react_btn;
         r_react_prev <= r_react_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_clr_flags = 1'b0;
      w_clr_cnt   = 1'b0;
      w_clr_seq   = 1'b0;
      w_inc_cnt   = 1'b0;
      w_inc_seq   = 1'b0;
      w_capture   = 1'b0;
      w_set_fs    = 1'b0;
      w_set_to    = 1'b0;
      case (r_state)
         S_IDLE, S_DONE, S_FAULT: begin
            if (w_start_edge) begin
               w_next      = S_ARM;
               w_clr_flags = 1'b1;
            end
         end
         S_ARM: begin
            w_next    = S_SEQ;
            w_clr_cnt = 1'b1;
            w_clr_seq = 1'b1;
         end
         // A react edge beats any light transition in the same cycle.
         S_SEQ: begin
            if (w_react_edge) begin
               w_next   = S_FAULT;
               w_set_fs = 1'b1;
            end else if (bus.lights == 8'hFF) begin
               w_next = S_HOLD;
            end else if (r_seq_cnt == 12'(SEQ_TO_MS)) begin
               w_next   = S_FAULT;
               w_set_to = 1'b1;
            end else if (bus.ms_tick) begin
               w_inc_seq = 1'b1;
            end
         end
         S_HOLD: begin
            if (w_react_edge) begin
               w_next   = S_FAULT;
               w_set_fs = 1'b1;
            end else if (bus.lights == 8'h00) begin
               w_next    = S_TIMING;
               w_clr_cnt = 1'b1;
            end
         end
         S_TIMING: begin
            if (w_react_edge) begin
               w_next    = S_DONE;
               w_capture = 1'b1;
            end else if (r_cnt == W'(MAX_MS)) begin
               w_next   = S_FAULT;
               w_set_to = 1'b1;
            end else if (bus.ms_tick) begin
               w_inc_cnt = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt         <= '0;
         r_seq_cnt     <= '0;
         r_res_valid   <= 1'b0;
         r_reaction_ms <= '0;
         r_false_start <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         if (w_clr_cnt)      r_cnt <= '0;
         else if (w_inc_cnt) r_cnt <= r_cnt + 1'b1;
         if (w_clr_seq)      r_seq_cnt <= '0;
         else if (w_inc_seq) r_seq_cnt <= r_seq_cnt + 1'b1;
         r_res_valid <= w_capture;
         if (w_capture) r_reaction_ms <= r_cnt;
         if (w_clr_flags) begin
            r_false_start <= 1'b0;
            r_timeout     <= 1'b0;
         end else begin
            if (w_set_fs) r_false_start <= 1'b1;
            if (w_set_to) r_timeout     <= 1'b1;
         end
      end
   end

`ifdef BEST_TIME_EN
   logic [W-1:0] r_best;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              r_best <= '1;
      else if (w_capture && (r_cnt < r_best)) r_best <= r_cnt;
   end

   assign bus.best_ms = r_best;
`else
   assign bus.best_ms = '1;
`endif

   assign bus.trigger     = (r_state == S_ARM);
   assign bus.busy        = (r_state == S_ARM) || (r_state == S_SEQ) ||
                            (r_state == S_HOLD) || (r_state == S_TIMING);
   assign bus.res_valid   = r_res_valid;
   assign bus.reaction_ms = r_reaction_ms;
   assign bus.false_start = r_false_start;
   assign bus.timeout     = r_timeout;
endmodule
